// File: rtl/gray_conv_arbiter_if.sv
// Handshake/bus bundle for gray_conv_arbiter.
// slave  : arbiter side (takes requests, drives grants and results)
// master : requester/consumer side
interface gray_conv_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] gray_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      bin_out;
  logic [IDW-1:0]    out_id;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  req, gray_in, out_ready,
    output gnt, bin_out, out_id, out_valid, busy
  );

  modport master (
    output req, gray_in, out_ready,
    input  gnt, bin_out, out_id, out_valid, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray->binary stage among NREQ
// requesters. Sequence per grant: IDLE (arbitrate+capture) -> CONV (convert)
// -> RESP (hold result until out_ready) -> IDLE.
// Optional feature macro: GRAY_ARB_LOCK_EN adds a 'lock' input that lets the
// last-served requester win the next arbitration again.
module gray_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef GRAY_ARB_LOCK_EN
  input  logic lock,
`endif
  gray_conv_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   gray_q;

  logic [IDW-1:0] idx;
  logic [IDW-1:0] rr_win;
  logic           rr_found;
  logic [IDW-1:0] sel_id;
  logic           sel_found;
  logic           lock_hit;
  logic [W-1:0]   bin_c;

  // Round-robin search upward from rr_ptr+1, wrapping at NREQ so an index
  // >= NREQ is never produced for non-power-of-two NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!rr_found && bus.req[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

`ifdef GRAY_ARB_LOCK_EN
  logic lock_q;

  // Remember the lock request made on the result handshake; it only matters
  // for the very next arbitration.
  always_ff @(posedge clk) begin
    if (rst)
      lock_q <= 1'b0;
    else if (state == RESP && bus.out_ready)
      lock_q <= lock;
    else if (state == IDLE && sel_found)
      lock_q <= 1'b0;
  end

  assign lock_hit = lock_q && bus.req[id_q];
`else
  assign lock_hit = 1'b0;
`endif

  // Final winner: locked owner if still requesting, otherwise round-robin.
  always_comb begin
    sel_id    = lock_hit ? id_q : rr_win;
    sel_found = lock_hit | rr_found;
  end

  // Gray->binary: bit i is the XOR of gray bits i..W-1.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < W; i++)
      bin_c[i] = ^(gray_q >> i);
  end

  // Sequencer FSM with registered grant/result/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= IDW'(NREQ - 1);
      id_q          <= '0;
      gray_q        <= '0;
      bus.gnt       <= '0;
      bus.bin_out   <= '0;
      bus.out_id    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gray_q   <= bus.gray_in[int'(sel_id)*W +: W];
            id_q     <= sel_id;
            // A lock re-grant leaves the round-robin position untouched.
            if (!lock_hit) rr_ptr <= sel_id;
            bus.gnt  <= NREQ'(1) << sel_id;
            bus.busy <= 1'b1;
            state    <= CONV;
          end else begin
            bus.gnt  <= '0;
          end
        end
        CONV: begin
          bus.bin_out   <= bin_c;
          bus.out_id    <= id_q;
          bus.out_valid <= 1'b1;
          bus.gnt       <= '0;
          state         <= RESP;
        end
        RESP: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: stimulus pushes expected grants and
// results, a negedge monitor pops and compares them. A second NREQ=3 instance
// covers the non-power-of-two wrap.
module tb_gray_conv_arbiter;
  logic clk = 1'b0;
  logic rst, rst3;
`ifdef GRAY_ARB_LOCK_EN
  logic lock, lock3;
`endif

  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.NREQ(4), .W(4)) m ();
  gray_conv_arbiter_if #(.NREQ(3), .W(4)) m3 ();

  gray_conv_arbiter #(.NREQ(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
`ifdef GRAY_ARB_LOCK_EN
    .lock(lock),
`endif
    .bus (m.slave)
  );

  gray_conv_arbiter #(.NREQ(3), .W(4)) u3 (
    .clk (clk),
    .rst (rst3),
`ifdef GRAY_ARB_LOCK_EN
    .lock(lock3),
`endif
    .bus (m3.slave)
  );

  typedef struct packed {
    logic [3:0] bin;
    logic [1:0] id;
  } res_t;

  logic [3:0] exp_gnt[$];
  res_t       exp_res[$];
  int nvec = 0;
  int nbad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] b, input logic [1:0] id);
    res_t r;
    r.bin = b;
    r.id  = id;
    exp_gnt.push_back(g);
    exp_res.push_back(r);
  endtask

  // Monitor: every grant pulse and every accepted result is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (m.gnt != '0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", m.gnt, 0);
        else check("gnt", m.gnt, exp_gnt.pop_front());
      end
      if (m.out_valid && m.out_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", m.bin_out, 32'hFFFF);
        else begin
          res_t e;
          e = exp_res.pop_front();
          check("bin_out", m.bin_out, e.bin);
          check("out_id", m.out_id, e.id);
        end
      end
    end
  end

  // Bounded wait for a grant pulse on the main instance (returns at negedge).
  task automatic wait_gnt(input int maxc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (m.gnt == '0 && n < maxc);
    if (m.gnt == '0) check("gnt_timeout", 0, 1);
  endtask

  // Bounded wait until every expected item has been consumed and block idle.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_gnt.size() != 0 || exp_res.size() != 0 || m.busy) && n < maxc);
    if (exp_gnt.size() != 0 || exp_res.size() != 0 || m.busy) check("drain_timeout", 0, 1);
  endtask

  task automatic wait3_gnt(input int maxc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (m3.gnt == '0 && n < maxc);
  endtask

  task automatic wait3_valid(input int maxc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!m3.out_valid && n < maxc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    m.req = '0; m.gray_in = '0; m.out_ready = 1'b1;
    m3.req = '0; m3.gray_in = '0; m3.out_ready = 1'b1;
`ifdef GRAY_ARB_LOCK_EN
    lock = 1'b0; lock3 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", m.gnt, 0);
    check("rst_valid", m.out_valid, 0);
    check("rst_busy", m.busy, 0);
    check("rst_bin", m.bin_out, 0);
    check("rst_id", m.out_id, 0);
    rst = 1'b0;

    // Single requester: gray 1101 -> binary 1001
    push(4'b0001, 4'b1001, 2'd0);
    m.gray_in = 16'h000D;
    m.req = 4'b0001;
    wait_gnt(10);
    @(posedge clk); #1;
    m.req = '0;
    check("lat_valid", m.out_valid, 1);
    check("lat_bin", m.bin_out, 4'b1001);
    drain(20);

    // Fairness from reset pointer: grants 0,1,2,3,0
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    push(4'b0001, 4'b0100, 2'd0);
    push(4'b0010, 4'b1111, 2'd1);
    push(4'b0100, 4'b0010, 2'd2);
    push(4'b1000, 4'b0000, 2'd3);
    push(4'b0001, 4'b0100, 2'd0);
    m.gray_in = {4'b0000, 4'b0011, 4'b1000, 4'b0110};
    m.req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_gnt(10);
    @(posedge clk); #1;
    m.req = '0;
    drain(30);

    // Backpressure: result held while out_ready=0, gray_in changes ignored
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    m.gray_in = 16'h0050;
    m.req = 4'b0010;
    push(4'b0010, 4'b0110, 2'd1);
    wait_gnt(10);
    @(posedge clk); #1;
    m.req = 4'b0100;
    m.gray_in = 16'h0FF0;
    for (int i = 0; i < 5; i++) begin
      check("bp_bin", m.bin_out, 4'b0110);
      check("bp_id", m.out_id, 1);
      check("bp_valid", m.out_valid, 1);
      check("bp_gnt", m.gnt, 0);
      check("bp_busy", m.busy, 1);
      @(posedge clk); #1;
    end
    push(4'b0100, 4'b1010, 2'd2);
    m.out_ready = 1'b1;
    wait_gnt(10);
    @(posedge clk); #1;
    m.req = '0;
    drain(20);

    // Reset during CONV discards the in-flight result
    @(posedge clk); #1;
    m.req = 4'b0100;
    exp_gnt.push_back(4'b0100);
    wait_gnt(10);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_valid", m.out_valid, 0);
    check("mid_gnt", m.gnt, 0);
    check("mid_busy", m.busy, 0);
    rst = 1'b0;
    m.req = 4'b0101;
    m.gray_in = 16'h0507;
    push(4'b0001, 4'b0101, 2'd0);
    wait_gnt(10);
    @(posedge clk); #1;
    m.req = '0;
    drain(20);

`ifdef GRAY_ARB_LOCK_EN
    // Lock: ID 1 re-granted over ID 0, then lock=0 restores round-robin
    @(posedge clk); #1;
    m.gray_in = 16'h0057;
    lock = 1'b1;
    m.req = 4'b0010;
    push(4'b0010, 4'b0110, 2'd1);
    push(4'b0010, 4'b0110, 2'd1);
    push(4'b0001, 4'b0101, 2'd0);
    wait_gnt(10);
    m.req = 4'b0011;
    wait_gnt(10);
    lock = 1'b0;
    wait_gnt(10);
    @(posedge clk); #1;
    m.req = '0;
    drain(20);
`endif

    // NREQ=3 wrap: rr_ptr=2 after reset, req=100 -> 2; req=101 -> 0 then 2
    @(posedge clk); #1;
    rst3 = 1'b0;
    m3.gray_in = {4'b0010, 4'b0000, 4'b1000};
    m3.req = 3'b100;
    wait3_gnt(10);
    check("w3_gnt_a", m3.gnt, 3'b100);
    m3.req = 3'b101;
    wait3_valid(10);
    check("w3_bin_a", m3.bin_out, 4'b0011);
    check("w3_id_a", m3.out_id, 2);
    wait3_gnt(10);
    check("w3_gnt_b", m3.gnt, 3'b001);
    wait3_valid(10);
    check("w3_bin_b", m3.bin_out, 4'b1111);
    check("w3_id_b", m3.out_id, 0);
    wait3_gnt(10);
    check("w3_gnt_c", m3.gnt, 3'b100);
    @(posedge clk); #1;
    m3.req = '0;
    repeat (4) @(posedge clk);
    #1;
    check("w3_idle", m3.busy, 0);

    check("q_gnt_empty", exp_gnt.size(), 0);
    check("q_res_empty", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
